// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer
// Drives the 4-LED green bank and the red status LED. A prescaler tick paces
// the patterns. A debounced mode button steps through four display modes:
// COUNT, SCAN, BREATHE and BLINK. The pause input freezes the pattern timing.
// The button path and the PWM counter keep running while paused.
module led_pattern_sequencer #(
  parameter int PRESCALE_W      = 24,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int PWM_W           = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       pause,
  output logic [3:0] gleds,
  output logic       rled,
  output logic [1:0] mode,
  output logic       tick
);

  // ---------------------------------------------------------------------------
  // Local constants
  // ---------------------------------------------------------------------------
  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  // Display modes. Encoding is visible on the mode port, so it is fixed.
  localparam logic [1:0] MODE_COUNT   = 2'd0;
  localparam logic [1:0] MODE_SCAN    = 2'd1;
  localparam logic [1:0] MODE_BREATHE = 2'd2;
  localparam logic [1:0] MODE_BLINK   = 2'd3;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic [PWM_W-1:0]      pwm_q, pwm_d;
  logic                  sync1_q, sync2_q;
  logic [DB_W-1:0]       db_cnt_q, db_cnt_d;
  logic                  db_level_q, db_level_d;
  logic [1:0]            mode_q, mode_d;
  logic [3:0]            step_q, step_d;
  logic [1:0]            pos_q, pos_d;
  logic                  dir_up_q, dir_up_d;
  logic [3:0]            gleds_q, gleds_d;
  logic                  rled_q;

  // Combinational control signals
  logic                  tick_w;
  logic                  mode_adv;
  logic [PWM_W-1:0]      pwm_base;
  logic [PWM_W-1:0]      duty;
  logic                  pwm_on;

  // ---------------------------------------------------------------------------
  // Prescaler
  // ---------------------------------------------------------------------------
  // The tick marks the cycle in which the prescaler wraps. A paused prescaler
  // sits still, so it must not tick.
  assign tick_w = (&presc_q) & ~pause;

  // Next prescaler value: hold while paused, otherwise count and wrap.
  always_comb begin
    presc_d = pause ? presc_q : presc_q + PRESCALE_W'(1);
  end

  // Prescaler register.
  always_ff @(posedge clk) begin
    // NOTE: registers are always written with <= so that every flop samples
    // the pre-edge values of the others, whatever order the blocks run in.
    if (reset) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Mode button: synchronizer and debouncer
  // ---------------------------------------------------------------------------
  // Two-flop synchronizer for the asynchronous button.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_mode;
      sync2_q <= sync1_q;
    end
  end

  // The debouncer accepts a new level once the synced input has disagreed
  // with the accepted level for DEBOUNCE_CYCLES cycles in a row. Any cycle of
  // agreement restarts the count. Only an accepted rising level advances the mode.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path can leave it unassigned and infer a latch.
    db_cnt_d   = db_cnt_q;
    db_level_d = db_level_q;
    mode_adv   = 1'b0;
    if (sync2_q == db_level_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      db_level_d = sync2_q;
      db_cnt_d   = '0;
      mode_adv   = sync2_q;
    end else begin
      db_cnt_d = db_cnt_q + DB_W'(1);
    end
  end

  // Debounce counter and accepted button level.
  always_ff @(posedge clk) begin
    if (reset) begin
      db_cnt_q   <= '0;
      db_level_q <= 1'b0;
    end else begin
      db_cnt_q   <= db_cnt_d;
      db_level_q <= db_level_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Mode FSM, step counter and scan position
  // ---------------------------------------------------------------------------
  // A mode change restarts the pattern and takes priority over a tick in the
  // same cycle. The tick in that cycle is dropped, not deferred. Scan position
  // bounces 0..3..0. The direction turns at the ends.
  always_comb begin
    mode_d   = mode_q;
    step_d   = step_q;
    pos_d    = pos_q;
    dir_up_d = dir_up_q;
    if (mode_adv) begin
      unique case (mode_q)
        MODE_COUNT:   mode_d = MODE_SCAN;
        MODE_SCAN:    mode_d = MODE_BREATHE;
        MODE_BREATHE: mode_d = MODE_BLINK;
        MODE_BLINK:   mode_d = MODE_COUNT;
        default:      mode_d = MODE_COUNT;
      endcase
      step_d   = 4'd0;
      pos_d    = 2'd0;
      dir_up_d = 1'b1;
    end else if (tick_w) begin
      step_d = step_q + 4'd1;
      if (mode_q == MODE_SCAN) begin
        if (dir_up_q) begin
          pos_d    = pos_q + 2'd1;
          dir_up_d = (pos_q != 2'd2);
        end else begin
          pos_d    = pos_q - 2'd1;
          dir_up_d = (pos_q == 2'd1);
        end
      end
    end
  end

  // Mode, step and scan registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q   <= MODE_COUNT;
      step_q   <= 4'd0;
      pos_q    <= 2'd0;
      dir_up_q <= 1'b1;
    end else begin
      mode_q   <= mode_d;
      step_q   <= step_d;
      pos_q    <= pos_d;
      dir_up_q <= dir_up_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Breathe PWM
  // ---------------------------------------------------------------------------
  // The duty cycle follows a triangle wave taken from the upper prescaler bits.
  // The top bit selects the rising or falling half. The bits below it give the level.
  assign pwm_base = presc_q[PRESCALE_W-2 -: PWM_W];
  assign duty     = presc_q[PRESCALE_W-1] ? ~pwm_base : pwm_base;
  assign pwm_on   = (pwm_q < duty);

  // The PWM counter free-runs, including while paused.
  always_comb begin
    pwm_d = pwm_q + PWM_W'(1);
  end

  // PWM counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_q <= '0;
    end else begin
      pwm_q <= pwm_d;
    end
  end

  // ---------------------------------------------------------------------------
  // LED outputs
  // ---------------------------------------------------------------------------
  // Pattern for the green bank, taken from the current mode and pattern state.
  always_comb begin
    gleds_d = 4'h0;
    unique case (mode_q)
      MODE_COUNT:   gleds_d = step_q;
      MODE_SCAN:    gleds_d = 4'b0001 << pos_q;
      MODE_BREATHE: gleds_d = {4{pwm_on}};
      MODE_BLINK:   gleds_d = step_q[0] ? 4'hF : 4'h0;
      default:      gleds_d = 4'h0;
    endcase
  end

  // Output registers. The red LED shows reset or pause.
  always_ff @(posedge clk) begin
    if (reset) begin
      gleds_q <= 4'h0;
      rled_q  <= 1'b1;
    end else begin
      gleds_q <= gleds_d;
      rled_q  <= pause;
    end
  end

  assign gleds = gleds_q;
  assign rled  = rled_q;
  assign mode  = mode_q;
  assign tick  = tick_w;

endmodule
